// File: rtl/pingpong_ram_ctrl.sv
// Ping-pong sequencer for a true-dual-port block RAM split into two banks.
// Port A fills one bank with the incoming sample stream while port B drains
// the other bank; banks swap when a bank completes, so the consumer sees
// whole frames back to back.
module pingpong_ram_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              enb,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        bank_full
);

    // Pointer width is one bit narrower than the RAM address: the MSB selects the bank.
    localparam int PTR_W = ADDR_W - 1;
    localparam logic [PTR_W-1:0] PTR_LAST = {PTR_W{1'b1}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    // Read sequencer states.
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_READ = 1'b1;

    // Write-side state.
    logic              wr_bank_q, wr_bank_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic              wr_hs;
    logic              wr_done;

    // Read-side state.
    logic [0:0]        state_q,   state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic              rd_done;
    logic              rd_is_last;

    // Shared bank occupancy.
    logic [1:0]        bank_full_q, bank_full_d;

    // Output alignment pipelines matching the RAM read latency.
    logic [RD_LAT-1:0] vld_q,  vld_d;
    logic [RD_LAT-1:0] last_q, last_d;

    // The writer may only fill its bank while that bank has been drained.
    assign in_ready = ~bank_full_q[wr_bank_q];

    // Write port: present the sample straight to port A on a handshake and advance the pointer.
    always_comb begin
        wr_hs     = in_valid & in_ready;
        wr_done   = wr_hs & (wr_ptr_q == PTR_LAST);
        wr_bank_d = wr_bank_q;
        wr_ptr_d  = wr_ptr_q;
        if (wr_hs) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (wr_done) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
        ena   = wr_hs;
        wea   = wr_hs;
        addra = {wr_bank_q, wr_ptr_q};
        dina  = in_data;
    end

    // Read sequencer: wait for a full bank, then stream all of it, chaining straight into the other bank if it is ready.
    always_comb begin
        state_d    = state_q;
        rd_bank_d  = rd_bank_q;
        rd_ptr_d   = rd_ptr_q;
        rd_done    = 1'b0;
        enb        = 1'b0;
        rd_is_last = (rd_ptr_q == PTR_LAST);
        case (state_q)
            R_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d  = R_READ;
                    rd_ptr_d = '0;
                end
            end
            R_READ: begin
                enb      = 1'b1;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (rd_is_last) begin
                    rd_done   = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    if (!bank_full_q[~rd_bank_q]) begin
                        state_d = R_IDLE;
                    end
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
        addrb = {rd_bank_q, rd_ptr_q};
        web   = 1'b0;
    end

    // Bank flags: the writer sets its bank when complete, the reader clears its bank after the final word; they never target the same bank.
    always_comb begin
        bank_full_d = bank_full_q;
        if (wr_done) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
        if (rd_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
    end

    // Delay the read strobe and frame-end marker so they line up with doutb.
    always_comb begin
        vld_d     = '0;
        last_d    = '0;
        vld_d[0]  = enb;
        last_d[0] = enb & rd_is_last;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
    end

    // State registers; reset discards any partially written bank and any in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            state_q     <= R_IDLE;
            rd_bank_q   <= 1'b0;
            rd_ptr_q    <= '0;
            bank_full_q <= 2'b00;
            vld_q       <= '0;
            last_q      <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            rd_ptr_q    <= rd_ptr_d;
            bank_full_q <= bank_full_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_last  = last_q[RD_LAT-1];
    assign out_data  = doutb;
    assign bank_full = bank_full_q;

endmodule

// File: tb/tb_pingpong_ram_ctrl.sv
// Testbench for pingpong_ram_ctrl: a RAM model sits on the RAM ports, a
// scoreboard queue holds every accepted sample in arrival order, and a
// monitor pops it whenever the controller presents an output word.
module tb_pingpong_ram_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 14;
    localparam int RD_LAT = 1;
    localparam int BANK   = 1 << (ADDR_W - 1);
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              ena, wea, enb, web;
    logic [ADDR_W-1:0] addra, addrb;
    logic [DATA_W-1:0] dina, doutb;
    logic              out_valid, out_last;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        bank_full;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   wr_cnt  = 0;
    int   rd_cnt  = 0;
    int   seq     = 0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    pingpong_ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .web(web), .addrb(addrb), .doutb(doutb),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .bank_full(bank_full)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural dual-port RAM with RD_LAT-cycle port-B read latency.
    always @(posedge clk) begin
        if (ena && wea) mem[addra] <= dina;
        if (enb) rd_pipe[0] <= mem[addrb];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign doutb = rd_pipe[RD_LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of input; on a handshake check port A against the model and push the expected output.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, output logic acc);
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        acc = v && in_ready;
        checkOutput("port_a_enables", {30'd0, ena, wea}, {30'd0, acc, acc});
        if (acc) begin
            checkOutput("addra", addra, wr_cnt % DEPTH);
            checkOutput("dina", dina, d);
            mon_e.data = d;
            mon_e.last = ((wr_cnt % BANK) == BANK - 1);
            exp_q.push_back(mon_e);
            wr_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    // Push n accepted words; mode 0 = always valid, 1 = alternating valid, 2 = random valid.
    task automatic sendWords(input int n, input int mode, input bit rnd);
        int sent = 0;
        int cyc  = 0;
        logic acc;
        logic v;
        logic [DATA_W-1:0] d;
        while (sent < n && cyc < n * 4 + 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            d = rnd ? DATA_W'($urandom) : DATA_W'(seq);
            applyStimulus(v, d, acc);
            if (acc) begin
                sent++;
                seq++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("words_accepted", sent, n);
    endtask

    // Assert reset right now, optionally check the asynchronous effect, then release it.
    task automatic doReset(input bit check);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        if (check) begin
            checkOutput("rst_in_ready", in_ready, 1);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_bank_full", bank_full, 0);
            checkOutput("rst_wea", wea, 0);
            checkOutput("rst_enb", enb, 0);
        end
        exp_q.delete();
        wr_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until only `leftover` unread samples remain, then confirm the controller is idle.
    task automatic waitDrain(input int leftover);
        int c = 0;
        while (exp_q.size() > leftover && c < 3000) begin
            @(posedge clk);
            c++;
        end
        checkOutput("drain_remaining", exp_q.size(), leftover);
        repeat (RD_LAT + 3) @(posedge clk);
        #1;
        checkOutput("idle_bank_full", bank_full, 0);
        checkOutput("idle_out_valid", out_valid, 0);
        checkOutput("idle_in_ready", in_ready, 1);
    endtask

    // Monitor: port B must walk the RAM linearly since reset, and every output word must match the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            rd_cnt = 0;
        end else begin
            if (enb) begin
                checkOutput("addrb", addrb, rd_cnt % DEPTH);
                checkOutput("web", web, 0);
                rd_cnt++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_out: got data 0x%0h, expected no output at %0t", out_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("out_data", out_data, mon_e.data);
                    checkOutput("out_last", out_last, mon_e.last);
                end
            end
        end
    end

    // Absolute time bound in case a wait is ever stuck.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        logic acc;
        #12;
        doReset(1'b1);

        // Single frame: latency and flag behaviour.
        seq = 0;
        sendWords(BANK, 0, 1'b0);
        checkOutput("single_bank_full", bank_full, 2'b01);
        for (int k = 0; k <= 1 + RD_LAT; k++) begin
            @(negedge clk);
            checkOutput("first_out_latency", out_valid, (k == 1 + RD_LAT));
        end
        waitDrain(0);

        // Continuous stream of four frames.
        seq = 0;
        sendWords(4 * BANK, 0, 1'b0);
        waitDrain(0);

        // Gapped input, alternating valid.
        seq = 0;
        sendWords(2 * BANK, 1, 1'b0);
        waitDrain(0);

        // Stall with both banks full, starting from bank 0.
        @(posedge clk);
        #3;
        doReset(1'b0);
        seq = 0;
        sendWords(2 * BANK, 0, 1'b0);
        checkOutput("stall_bank_full", bank_full, 2'b11);
        checkOutput("stall_in_ready", in_ready, 0);
        applyStimulus(1'b1, DATA_W'(seq), acc);
        in_valid = 1'b0;
        checkOutput("stall_rejected", acc, 0);
        checkOutput("after_stall_in_ready", in_ready, 1);
        checkOutput("after_stall_addra", addra, 0);
        sendWords(BANK, 0, 1'b0);
        waitDrain(0);

        // Reset while reading word 200, with a partial second bank in progress.
        @(posedge clk);
        #3;
        doReset(1'b0);
        seq = 0;
        sendWords(BANK, 0, 1'b0);
        sendWords(100, 0, 1'b0);
        repeat (101) @(posedge clk);
        #3;
        checkOutput("pre_reset_addrb", addrb, 200);
        checkOutput("pre_reset_out_valid", out_valid, 1);
        doReset(1'b1);
        sendWords(BANK, 0, 1'b1);
        waitDrain(0);

        // Random valid pattern and random data, ending with a partial bank.
        sendWords(4 * BANK + 300, 2, 1'b1);
        waitDrain(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
